hall_call_dispatcher: RTL

Parametrised hall-call dispatcher for an NUM_CARS-car, NUM_FLOORS-floor elevator bank. It sits between the hall up/down buttons and the per-car `Elevator` instances. It does the following:
- latches hall calls;
- assigns each unassigned call to exactly one eligible car by a sequential nearest-car scan;
- clears calls when a car serves them;
- revokes assignments that go unserved for REASSIGN_CYCLES so they can be re-dispatched.

---
 rtl/hall_call_dispatcher.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: latches hall calls and hands each one to the nearest eligible car
module hall_call_dispatcher #(
    parameter int NUM_FLOORS = 7,
    parameter int NUM_CARS = 2,
    parameter int FLOOR_W = 3,
    parameter int REASSIGN_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_FLOORS-1:0]          hall_up_req,
    input  logic [NUM_FLOORS-1:0]          hall_dn_req,
    input  logic [NUM_CARS*FLOOR_W-1:0]    car_floor,
    input  logic [2*NUM_CARS-1:0]          car_dir,
    input  logic [NUM_CARS-1:0]            car_door_open,
    output logic [NUM_FLOORS-1:0]          hall_up_lamp,
    output logic [NUM_FLOORS-1:0]          hall_dn_lamp,
    output logic [NUM_CARS*NUM_FLOORS-1:0] car_assign_up,
    output logic [NUM_CARS*NUM_FLOORS-1:0] car_assign_dn,
    output logic                           busy
);
    localparam int K = 2 * NUM_FLOORS;
    localparam int KW = $clog2(K);
    localparam int CW = NUM_CARS > 1 ? $clog2(NUM_CARS) : 1;
    localparam int TW = $clog2(REASSIGN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SCAN, EVAL, COMMIT} state_t;

    state_t              state, state_n;
    logic [KW-1:0]       kp, kp_n, kp_inc;
    logic [CW-1:0]       cc, cc_n, best, best_n;
    logic [FLOOR_W-1:0]  best_cost, best_cost_n;
    logic                bv, bv_n;
    logic [K-1:0]        pend, req, served, cand;
    logic [NUM_CARS-1:0] asg [K];
    logic [TW-1:0]       cnt [K];
    logic [FLOOR_W-1:0]  cf, fl, cost;
    logic [1:0]          cd;
    logic                up_call, elig, do_commit, at, stop, su, sd;

    // requests with the meaningless top-up / bottom-down buttons masked, and per-call serve detection
    always_comb begin
        req = '0;
        served = '0;
        at = 1'b0;
        stop = 1'b0;
        su = 1'b0;
        sd = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            req[f] = hall_up_req[f] & (f != NUM_FLOORS - 1);
            req[NUM_FLOORS+f] = hall_dn_req[f] & (f != 0);
            su = 1'b0;
            sd = 1'b0;
            for (int c = 0; c < NUM_CARS; c++) begin
                at = car_door_open[c] && car_floor[c*FLOOR_W +: FLOOR_W] == FLOOR_W'(f);
                stop = car_dir[2*c +: 2] == 2'b00 || car_dir[2*c +: 2] == 2'b11;
                su = su | (at && (stop || car_dir[2*c +: 2] == 2'b10));
                sd = sd | (at && (stop || car_dir[2*c +: 2] == 2'b01));
            end
            served[f] = su;
            served[NUM_FLOORS+f] = sd;
        end
    end

    // a call is a dispatch candidate while it is pending and owned by no car
    always_comb begin
        cand = '0;
        for (int k = 0; k < K; k++) cand[k] = pend[k] & ~(|asg[k]);
    end

    // cost and eligibility of the car under evaluation against call kp, using live car inputs
    always_comb begin
        up_call = kp < KW'(NUM_FLOORS);
        fl = FLOOR_W'(up_call ? kp : kp - KW'(NUM_FLOORS));
        cf = car_floor[cc*FLOOR_W +: FLOOR_W];
        cd = car_dir[2*cc +: 2];
        cost = cf > fl ? cf - fl : fl - cf;
        elig = cd == 2'b00 || cd == 2'b11 || (cd == 2'b10 && up_call && cf <= fl) ||
               (cd == 2'b01 && !up_call && cf >= fl);
        kp_inc = kp == KW'(K - 1) ? '0 : kp + KW'(1);
        do_commit = state == COMMIT && bv && cand[kp];
    end

    // scan FSM: walk the calls round-robin, evaluate one car per cycle, then commit the best
    always_comb begin
        state_n = state;
        kp_n = kp;
        cc_n = cc;
        bv_n = bv;
        best_n = best;
        best_cost_n = best_cost;
        case (state)
            IDLE: state_n = |cand ? SCAN : IDLE;
            SCAN: begin
                if (!(|cand)) state_n = IDLE;
                else if (cand[kp]) begin
                    state_n = EVAL;
                    cc_n = '0;
                    bv_n = 1'b0;
                end else kp_n = kp_inc;
            end
            EVAL: begin
                if (served[kp]) begin
                    state_n = SCAN;
                    kp_n = kp_inc;
                end else begin
                    if (elig && (!bv || cost < best_cost)) begin
                        bv_n = 1'b1;
                        best_n = cc;
                        best_cost_n = cost;
                    end
                    if (cc == CW'(NUM_CARS - 1)) state_n = COMMIT;
                    else cc_n = cc + CW'(1);
                end
            end
            COMMIT: begin
                state_n = SCAN;
                kp_n = kp_inc;
            end
            default: state_n = IDLE;
        endcase
    end

    // scan FSM and evaluation registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            kp <= '0;
            cc <= '0;
            bv <= 1'b0;
            best <= '0;
            best_cost <= '0;
        end else begin
            state <= state_n;
            kp <= kp_n;
            cc <= cc_n;
            bv <= bv_n;
            best <= best_n;
            best_cost <= best_cost_n;
        end
    end

    // per-call pending, owner and age; serving beats a same-cycle request and any assignment
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            for (int k = 0; k < K; k++) begin
                asg[k] <= '0;
                cnt[k] <= '0;
            end
        end else begin
            pend <= ~served & (pend | req);
            for (int k = 0; k < K; k++) begin
                if (served[k] || (|asg[k] && cnt[k] == TW'(REASSIGN_CYCLES))) begin
                    asg[k] <= '0;
                    cnt[k] <= '0;
                end else if (|asg[k]) cnt[k] <= cnt[k] + TW'(1);
                else if (do_commit && kp == KW'(k)) begin
                    asg[k] <= NUM_CARS'(1) << best;
                    cnt[k] <= '0;
                end
            end
        end
    end

    // lamps mirror pending calls; ownership is spread into the per-car assign vectors
    always_comb begin
        car_assign_up = '0;
        car_assign_dn = '0;
        for (int f = 0; f < NUM_FLOORS; f++)
            for (int c = 0; c < NUM_CARS; c++) begin
                car_assign_up[c*NUM_FLOORS+f] = asg[f][c];
                car_assign_dn[c*NUM_FLOORS+f] = asg[NUM_FLOORS+f][c];
            end
    end

    assign hall_up_lamp = pend[NUM_FLOORS-1:0];
    assign hall_dn_lamp = pend[K-1:NUM_FLOORS];
    assign busy = state != IDLE;
endmodule
